// File: rtl/instr_fetch.sv
// RV64 fetch front end: one outstanding imem request feeding a DEPTH-entry {pc,instr} prefetch FIFO; FETCH_ALIGN_CHECK_EN traps misaligned redirects.
// Accept N -> rvalid N+1 -> out_valid N+2 (no bypass); out_ready low fills the FIFO (reserved slot included) and then imem_req drops.
module instr_fetch #(
  parameter int            BITS     = 63,
  parameter int            DEPTH    = 4,
  parameter logic [BITS:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [BITS:0]   imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [BITS:0]   redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [BITS:0]   out_pc,
  output logic            fetch_fault
);
  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [BITS:0]   fetch_pc_q, fetch_pc_d;
  logic [BITS:0]   req_pc_q, req_pc_d;
  logic            pending_q, pending_d;
  logic            discard_q, discard_d;
  logic            fault_q, fault_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [BITS:0]   pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            accept, resp, push, pop;
  logic [BITS:0]   redirect_aligned;

  // The in-flight request's slot is already reserved: pending blocks a new
  // request, so count < DEPTH at acceptance guarantees room for the response.
  assign imem_req  = reset && !pending_q && (count_q < DEPTH_C) && !fault_q;
  assign imem_addr = fetch_pc_q;
  assign accept    = imem_req && imem_ack;
  assign resp      = imem_rvalid && pending_q;
  assign push      = resp && !discard_q && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign redirect_aligned = {redirect_pc[BITS:2], 2'b00};

  assign out_valid   = (count_q != '0);
  assign out_instr   = out_valid ? instr_mem[rd_ptr_q] : NOP;
  assign out_pc      = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign fetch_fault = fault_q;

`ifdef FETCH_ALIGN_CHECK_EN
  always_comb begin
    fault_d = fault_q;
    if (redirect) begin
      fault_d = (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_redirect_low;
  assign unused_redirect_low = ^redirect_pc[1:0];
  assign fault_d = 1'b0;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    pending_d  = pending_q;
    discard_d  = discard_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    if (accept) begin
      pending_d  = 1'b1;
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + (BITS+1)'(4);
    end else if (resp) begin
      pending_d = 1'b0;
      discard_d = 1'b0;
    end

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // Redirect wins: anything still owed by memory from the old stream is stale.
    if (redirect) begin
      fetch_pc_d = redirect_aligned;
      discard_d  = accept || (pending_q && !imem_rvalid);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      pending_q  <= 1'b0;
      discard_q  <= 1'b0;
      fault_q    <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      pending_q  <= pending_d;
      discard_q  <= discard_d;
      fault_q    <= fault_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: out_valid masks every slot until it is written.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= req_pc_q;
      instr_mem[wr_ptr_q] <= imem_rdata;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (!reset) count_q <= DEPTH_C);
  a_addr_align:  assert property (@(posedge clk) disable iff (!reset) imem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a cycle-stepped memory model answers each accepted request one cycle later unless held back.
module tb_instr_fetch;
  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        fetch_fault;

  int          n_pass;
  int          n_total;
  logic        auto_rsp;
  logic [63:0] acc_log[$];

  instr_fetch dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .fetch_fault(fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return 32'h0050_0093 ^ a[31:0];
  endfunction

  function automatic logic [63:0] last_acc();
    return (acc_log.size() > 0) ? acc_log[acc_log.size()-1] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  // One clock: sample the handshake before the edge, then model memory after it.
  task automatic tick();
    logic        acc;
    logic [63:0] a;
    #1;
    acc = imem_req && imem_ack;
    a   = imem_addr;
    @(posedge clk);
    #1;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
    if (acc) begin
      acc_log.push_back(a);
      if (auto_rsp) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(a);
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; redirect = 1'b0; out_ready = 1'b0; imem_rvalid = 1'b0;
    imem_ack = 1'b1; auto_rsp = 1'b1;
    tick();
    reset = 1'b1;
    acc_log.delete();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %0h want 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 64'h0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (out_instr !== 32'h0000_0013) $display("FAIL rst_instr: got %h want 00000013", out_instr); else n_pass++;
    n_total++; if (out_pc !== 64'h0) $display("FAIL rst_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL rst_fault: got %0h want 0", fetch_fault); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b1) $display("FAIL rel_req: got %0h want 1", imem_req); else n_pass++;
    tick();
    n_total++; if (last_acc() !== 64'h0) $display("FAIL first_addr: got %h want 0", last_acc()); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL lat_n1_valid: got %0h want 0", out_valid); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL lat_n2_valid: got %0h want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h0) $display("FAIL lat_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_instr !== 32'h0050_0093) $display("FAIL lat_instr: got %h want 00500093", out_instr); else n_pass++;
  endtask

  task automatic test_backpressure_fill();
    logic [63:0] exp_pc;
    do_reset();
    repeat (12) tick();
    n_total++; if (acc_log.size() != 4) $display("FAIL fill_count: got %0d want 4", acc_log.size()); else n_pass++;
    for (int i = 0; i < 4 && i < acc_log.size(); i++) begin
      exp_pc = 64'(i * 4);
      n_total++; if (acc_log[i] !== exp_pc) $display("FAIL fill_addr%0d: got %h want %h", i, acc_log[i], exp_pc); else n_pass++;
    end
    n_total++; if (imem_req !== 1'b0) $display("FAIL fill_req: got %0h want 0", imem_req); else n_pass++;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_pc = 64'(i * 4);
      n_total++; if (out_valid !== 1'b1) $display("FAIL drain_valid%0d: got %0h want 1", i, out_valid); else n_pass++;
      n_total++; if (out_pc !== exp_pc) $display("FAIL drain_pc%0d: got %h want %h", i, out_pc, exp_pc); else n_pass++;
      n_total++; if (out_instr !== word_of(exp_pc)) $display("FAIL drain_instr%0d: got %h want %h", i, out_instr, word_of(exp_pc)); else n_pass++;
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    do_reset();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'h10;
    tick();
    n_total++; if (imem_addr !== 64'h10) $display("FAIL infl_addr: got %h want 10", imem_addr); else n_pass++;
    auto_rsp = 1'b0; imem_ack = 1'b1; out_ready = 1'b1;
    tick();
    n_total++; if (last_acc() !== 64'h10) $display("FAIL infl_acc: got %h want 10", last_acc()); else n_pass++;
    redirect = 1'b1; redirect_pc = 64'h200;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL infl_valid0: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL infl_blocked: got %0h want 0", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 64'h200) $display("FAIL infl_newaddr: got %h want 200", imem_addr); else n_pass++;
    imem_rvalid = 1'b1; imem_rdata = word_of(64'h10); auto_rsp = 1'b1;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL infl_dropped: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL infl_resume: got %0h want 1", imem_req); else n_pass++;
    tick();
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL infl_valid1: got %0h want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h200) $display("FAIL infl_pc: got %h want 200", out_pc); else n_pass++;
    n_total++; if (out_instr !== word_of(64'h200)) $display("FAIL infl_instr: got %h want %h", out_instr, word_of(64'h200)); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_collision();
    int          old_seen;
    logic [63:0] first_pc;
    logic [31:0] first_instr;
    logic        got_first;
    do_reset();
    tick();
    tick();
    tick();
    out_ready = 1'b1; redirect = 1'b1; redirect_pc = 64'h300;
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL coll_empty: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (imem_addr !== 64'h300) $display("FAIL coll_addr: got %h want 300", imem_addr); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL coll_req: got %0h want 1", imem_req); else n_pass++;
    old_seen = 0; got_first = 1'b0; first_pc = '1; first_instr = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        if (out_pc < 64'h300) old_seen++;
        if (!got_first) begin
          got_first = 1'b1; first_pc = out_pc; first_instr = out_instr;
        end
      end
    end
    n_total++; if (old_seen != 0) $display("FAIL coll_old: got %0d want 0", old_seen); else n_pass++;
    n_total++; if (first_pc !== 64'h300) $display("FAIL coll_first_pc: got %h want 300", first_pc); else n_pass++;
    n_total++; if (first_instr !== word_of(64'h300)) $display("FAIL coll_first_instr: got %h want %h", first_instr, word_of(64'h300)); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_align();
    do_reset();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'h102;
    tick();
`ifdef FETCH_ALIGN_CHECK_EN
    n_total++; if (fetch_fault !== 1'b1) $display("FAIL align_fault: got %0h want 1", fetch_fault); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL align_halt: got %0h want 0", imem_req); else n_pass++;
    redirect = 1'b1; redirect_pc = 64'h100;
    tick();
`endif
    n_total++; if (fetch_fault !== 1'b0) $display("FAIL align_nofault: got %0h want 0", fetch_fault); else n_pass++;
    n_total++; if (imem_req !== 1'b1) $display("FAIL align_req: got %0h want 1", imem_req); else n_pass++;
    n_total++; if (imem_addr !== 64'h100) $display("FAIL align_addr: got %h want 100", imem_addr); else n_pass++;
    imem_ack = 1'b1;
    tick();
    n_total++; if (last_acc() !== 64'h100) $display("FAIL align_acc: got %h want 100", last_acc()); else n_pass++;
  endtask

  task automatic test_pc_wrap();
    do_reset();
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    imem_ack = 1'b1;
    tick();
    tick();
    n_total++; if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL wrap_pc: got %h want fffffffffffffffc", out_pc); else n_pass++;
    n_total++; if (out_instr !== word_of(64'hFFFF_FFFF_FFFF_FFFC)) $display("FAIL wrap_instr: got %h want %h", out_instr, word_of(64'hFFFF_FFFF_FFFF_FFFC)); else n_pass++;
    n_total++; if (imem_addr !== 64'h0) $display("FAIL wrap_next: got %h want 0", imem_addr); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    tick();
    tick();
    n_total++; if (imem_rvalid !== 1'b1) $display("FAIL mid_setup: got %0h want 1", imem_rvalid); else n_pass++;
    reset = 1'b0;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL mid_req: got %0h want 0", imem_req); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_valid: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (out_instr !== 32'h0000_0013) $display("FAIL mid_instr: got %h want 00000013", out_instr); else n_pass++;
    n_total++; if (out_pc !== 64'h0) $display("FAIL mid_pc: got %h want 0", out_pc); else n_pass++;
    n_total++; if (imem_addr !== 64'h0) $display("FAIL mid_addr: got %h want 0", imem_addr); else n_pass++;
    reset = 1'b1;
    acc_log.delete();
    tick();
    n_total++; if (out_valid !== 1'b0) $display("FAIL mid_stale: got %0h want 0", out_valid); else n_pass++;
    n_total++; if (last_acc() !== 64'h0) $display("FAIL mid_refetch: got %h want 0", last_acc()); else n_pass++;
    tick();
    n_total++; if (out_valid !== 1'b1) $display("FAIL mid_valid1: got %0h want 1", out_valid); else n_pass++;
    n_total++; if (out_pc !== 64'h0) $display("FAIL mid_pc1: got %h want 0", out_pc); else n_pass++;
    n_total++; if (out_instr !== 32'h0050_0093) $display("FAIL mid_instr1: got %h want 00500093", out_instr); else n_pass++;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; imem_ack = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0; auto_rsp = 1'b1;
    test_reset();
    test_backpressure_fill();
    test_redirect_inflight();
    test_redirect_collision();
    test_align();
    test_pc_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

- Instruction fetch front end for the 64-bit RISC-V core.
- Issues word requests to instruction memory over a req/ack/rvalid handshake and buffers returned words with their PCs in a `DEPTH`-entry prefetch FIFO.
- Delivers them downstream to decode/datapath through a valid/ready port.
- Accepts branch/jump redirects that flush the FIFO and discard stale in-flight data.

## Interface
Parameters:
- `BITS`, 63, PC is `BITS+1` bits wide
- `DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)
- `RESET_PC`, 0, first fetch address after reset

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  BITS+1  byte address of request, always word-aligned
- `imem_ack`  in  1  memory accepts the request; transfer occurs when `imem_req && imem_ack`
- `imem_rvalid`  in  1  response word valid; exactly one per accepted request, ≥1 cycle after acceptance
- `imem_rdata`  in  32  response instruction word
- `redirect`  in  1  one-cycle pulse, taken branch/jal/jalr
- `redirect_pc`  in  BITS+1  new fetch address
- `out_valid`  out  1  `out_instr`/`out_pc` hold a valid instruction
- `out_ready`  in  1  consumer accepts head entry when `out_valid && out_ready`
- `out_instr`  out  32  instruction at FIFO head
- `out_pc`  out  BITS+1  PC of `out_instr`
- `fetch_fault`  out  1  misaligned redirect trapped (see Configuration)

## Operation
- **Registers:**
  - `fetch_pc`: next address to request
  - `pending`: one request accepted, response not yet returned
  - `discard`: the pending response is stale
  - FIFO of `{pc, instr}`
- **Outstanding requests:** at most one at any time.
- **Request issue:** `imem_req` = !`pending` && (FIFO count < `DEPTH`) && !fault-halt. `imem_addr` = `fetch_pc`.
  - `imem_addr` may change while a request is unacked; memory samples only on acceptance.
  - On acceptance: `pending` ← 1, `fetch_pc` ← `fetch_pc + 4`.
  - The FIFO entry reserved for the in-flight request counts toward full, so a response is never dropped for lack of space.
- **Response:**
  - `imem_rvalid` with `pending && !discard`: push `{pc of request, imem_rdata}`, then `pending` ← 0.
  - `imem_rvalid` with `discard`: drop the word, then clear `pending` and `discard`.
- **Pop:** `out_valid && out_ready` removes the head entry.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- **Redirect** (highest priority):
  - FIFO emptied. A same-cycle pop or push is ignored.
  - `fetch_pc` ← `{redirect_pc[BITS:2], 2'b00}`.
  - If a request is pending, or is accepted in the redirect cycle, `discard` ← 1.
- **Response during redirect:** `imem_rvalid` in the redirect cycle is always dropped and clears `pending`.
- **Idle outputs:** when `out_valid`=0, `out_instr` = 32'h0000_0013 (NOP) and `out_pc` = 0.
- **PC arithmetic:** modulo 2^(BITS+1); `fetch_pc` wraps from all-ones-minus-3 to 0 with no flag.

## Timing
- **Reset values (async assert):**
  - `imem_req`=0 while `reset` low
  - `imem_addr`=`RESET_PC`
  - `out_valid`=0, `out_instr`=0x13, `out_pc`=0
  - `fetch_fault`=0
  - FIFO empty, `pending`=0, `discard`=0
- **After reset release:** `imem_req`=1 in the first cycle after `reset` deasserts.
- **Latency:** accepted in cycle N, `imem_rvalid` in N+1, `out_valid` in N+2. The FIFO is registered with no bypass.
- **Redirect latency:**
  - `out_valid`=0 in the cycle after `redirect`.
  - New request issued in that same cycle if not blocked by a stale pending response.
- **Throughput:** one instruction per 2 cycles with a zero-wait memory (single outstanding request).
- **Reset mid-transaction:** all state is cleared immediately. A late `imem_rvalid` after reset with `pending`=0 is ignored.

## Configuration
- **`FETCH_ALIGN_CHECK_EN` defined:**
  - A redirect with `redirect_pc[1:0]` ≠ 0 sets `fetch_fault`=1 from the next cycle and halts fetch (`imem_req`=0).
  - The FIFO is still flushed.
  - `fetch_fault` clears and fetch resumes on the next aligned redirect or on reset.
- **Undefined:**
  - `redirect_pc[1:0]` is silently forced to 0.
  - `fetch_fault` is tied 0.

## Test plan
- **Reset fetch:** release reset; memory acks immediately, returns 0x00500093 next cycle → `imem_addr`=0 first, `out_valid`=1 with `out_pc`=0, `out_instr`=0x00500093 two cycles after acceptance.
- **Backpressure fill:** `out_ready`=0, zero-wait memory → exactly 4 words fetched (`imem_addr` 0,4,8,12), then `imem_req` stays 0. `out_ready`=1 → drains in order with PCs 0,4,8,12.
- **Redirect with in-flight request:** request for 0x10 accepted; `redirect` to 0x200 before `imem_rvalid` → returned word dropped, `out_valid` next asserts with `out_pc`=0x200.
- **Redirect collision:** `redirect`, `out_ready` and a push in the same cycle → FIFO empty next cycle, no instruction from the old stream ever appears.
- **Alignment check:** with `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fetch_fault`=1, no requests; redirect to 0x100 → fault clears, fetch resumes at 0x100. Without the macro → fetch at 0x100 directly.
- **Reset mid-fetch:** assert `reset` while `pending`=1 → outputs at reset values immediately; stale `imem_rvalid` ignored; refetch starts at `RESET_PC`.
